// File: rtl/sccb_config_sequencer.sv
// Walks a register-init table in a synchronous ROM and drives a byte-level I2C
// master through 3-phase SCCB writes, with delay/end markers, NACK retry and abort.
module sccb_config_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h42,
    parameter int         REG_ADDR_BYTES = 1,
    parameter int         ROM_DEPTH      = 128,
    parameter int         DELAY_UNIT_CYC = 100000,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYC        = 16,
    localparam int        EW             = 8*REG_ADDR_BYTES + 8,
    localparam int        AW             = $clog2(ROM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] cur_index,
    output logic [AW-1:0] rom_addr,
    input  logic [EW-1:0] rom_data,
    output logic          i2c_start,
    output logic          i2c_en,
    output logic          i2c_stop,
    output logic [7:0]    tx_data,
    input  logic          tx_ready,
    input  logic          tx_done,
    input  logic          rd_ack
);
    localparam int NB = REG_ADDR_BYTES + 2;
    localparam int CW = $clog2(255*DELAY_UNIT_CYC + GAP_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = EW + 8;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_ROM, S_DECODE, S_START, S_SEND, S_WAIT_DONE,
        S_STOP, S_STOP_WAIT, S_GAP, S_DELAY, S_NEXT, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [EW-1:0] ent_q, ent_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nack_q, nack_d, abort_q, abort_d, error_q, error_d;

    logic [EW-9:0] ent_addr;
    logic [7:0]    ent_data;
    logic          abt;

    assign ent_addr  = ent_q[EW-1:8];
    assign ent_data  = ent_q[7:0];
    assign abt       = abort_q | abort;
    assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done      = (state_q == S_FINISH);
    assign error     = error_q;
    assign cur_index = idx_q;
    assign rom_addr  = idx_q;
    // Outgoing bytes are shifted out MSB-first: DEV_ADDR, reg_addr (high first), reg_data.
    assign tx_data   = sh_q[SW-1 -: 8];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ent_d     = ent_q;
        sh_d      = sh_q;
        bcnt_d    = bcnt_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        nack_d    = nack_q;
        abort_d   = abt;
        error_d   = error_q;
        i2c_start = 1'b0;
        i2c_en    = 1'b0;
        i2c_stop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else state_d = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                ent_d = rom_data;
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else state_d = S_DECODE;
            end
            S_DECODE: begin
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else if (&ent_addr) begin
                    if (ent_data == 8'hFF) state_d = S_FINISH;
                    else if (ent_data == 8'h00) state_d = S_NEXT;
                    else begin
                        cnt_d   = CW'(32'(ent_data) * 32'(DELAY_UNIT_CYC));
                        state_d = S_DELAY;
                    end
                end else state_d = S_START;
            end
            S_START: begin
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else if (tx_ready) begin
                    i2c_start = 1'b1;
                    sh_d      = {DEV_ADDR, ent_q};
                    bcnt_d    = '0;
                    nack_d    = 1'b0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (abt) state_d = S_STOP;
                else if (tx_ready) begin
                    i2c_en  = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    if (rd_ack) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (abt || bcnt_q == 2'(NB - 1)) state_d = S_STOP;
                    else begin
                        sh_d    = {sh_q[SW-9:0], 8'h00};
                        bcnt_d  = bcnt_q + 2'd1;
                        state_d = S_SEND;
                    end
                end
            end
            S_STOP: begin
                if (tx_ready) begin
                    i2c_stop = 1'b1;
                    state_d  = S_STOP_WAIT;
                end
            end
            S_STOP_WAIT: begin
                if (tx_ready) begin
                    cnt_d   = CW'(GAP_CYC);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
                else if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else if (nack_q) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_START;
                    end else begin
                        state_d = S_FINISH;
                        error_d = 1'b1;
                    end
                end else begin
                    retry_d = '0;
                    state_d = S_NEXT;
                end
            end
            S_DELAY: begin
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else if (cnt_q > CW'(1)) cnt_d = cnt_q - CW'(1);
                else state_d = S_NEXT;
            end
            S_NEXT: begin
                if (abt) begin state_d = S_FINISH; error_d = 1'b1; end
                else if (idx_q == AW'(ROM_DEPTH - 1)) state_d = S_FINISH;
                else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ent_q   <= '0;
            sh_q    <= '0;
            bcnt_q  <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            nack_q  <= 1'b0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ent_q   <= ent_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            nack_q  <= nack_d;
            abort_q <= abort_d;
            error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: a byte-level I2C master model with scripted NACKs,
// directed vector table, corner-case sequences and randomized tables vs a transaction model.
module tb_sccb_config_sequencer;
    localparam int GAP = 4, UNIT = 10, MR = 3, D0 = 8, D1 = 4;
    localparam int EV_S = 256, EV_P = 512, BUDGET = 4000;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    logic start0 = 1'b0, abort0 = 1'b0, busy0, done0, err0, ist0, ien0, istp0;
    logic [2:0]  idx0, raddr0;
    logic [15:0] rdata0;
    logic [7:0]  txd0;
    logic start1 = 1'b0, abort1 = 1'b0, busy1, done1, err1, ist1, ien1, istp1;
    logic [1:0]  idx1, raddr1;
    logic [23:0] rdata1;
    logic [7:0]  txd1;
    logic rdy[2], dn[2], ack[2];

    logic [15:0] rom0[D0];
    logic [23:0] rom1[D1];
    always @(posedge clk) begin
        rdata0 <= rom0[raddr0];
        rdata1 <= rom1[raddr1];
    end

    sccb_config_sequencer #(.DEV_ADDR(8'h42), .REG_ADDR_BYTES(1), .ROM_DEPTH(D0),
        .DELAY_UNIT_CYC(UNIT), .MAX_RETRY(MR), .GAP_CYC(GAP)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .busy(busy0),
        .done(done0), .error(err0), .cur_index(idx0), .rom_addr(raddr0),
        .rom_data(rdata0), .i2c_start(ist0), .i2c_en(ien0), .i2c_stop(istp0),
        .tx_data(txd0), .tx_ready(rdy[0]), .tx_done(dn[0]), .rd_ack(ack[0]));

    sccb_config_sequencer #(.DEV_ADDR(8'h42), .REG_ADDR_BYTES(2), .ROM_DEPTH(D1),
        .DELAY_UNIT_CYC(UNIT), .MAX_RETRY(MR), .GAP_CYC(GAP)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .busy(busy1),
        .done(done1), .error(err1), .cur_index(idx1), .rom_addr(raddr1),
        .rom_data(rdata1), .i2c_start(ist1), .i2c_en(ien1), .i2c_stop(istp1),
        .tx_data(txd1), .tx_ready(rdy[1]), .tx_done(dn[1]), .rd_ack(ack[1]));

    // Master model: accepts one command while ready, stays busy 1..3 cycles, then
    // pulses tx_done for bytes. NACK decisions for instance 0 come from nack_tab in byte order.
    logic cs[2], ce[2], cp[2];
    logic [7:0] td[2];
    assign cs[0] = ist0; assign ce[0] = ien0; assign cp[0] = istp0; assign td[0] = txd0;
    assign cs[1] = ist1; assign ce[1] = ien1; assign cp[1] = istp1; assign td[1] = txd1;
    int lat[2];
    bit pend[2];
    bit nack_tab[1024];
    int byte_no = 0, viol = 0, dcnt0 = 0, dcnt1 = 0, st_cyc = 0, first_st = -1;
    int ev0[$], ev1[$], exp_ev[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            dn[i] <= 1'b0;
            if (!reset) begin
                rdy[i] <= 1'b1; lat[i] <= 0; pend[i] <= 1'b0; ack[i] <= 1'b0;
            end else begin
                if ((int'(cs[i]) + int'(ce[i]) + int'(cp[i]) > 1) ||
                    ((cs[i] | ce[i] | cp[i]) && !rdy[i])) viol <= viol + 1;
                if (lat[i] > 0) begin
                    lat[i] <= lat[i] - 1;
                    if (lat[i] == 1) begin
                        rdy[i] <= 1'b1;
                        if (pend[i]) begin
                            dn[i]  <= 1'b1;
                            ack[i] <= (i == 0) ? nack_tab[byte_no] : 1'b0;
                            if (i == 0) byte_no <= byte_no + 1;
                        end
                    end
                end else if (rdy[i] && (cs[i] | ce[i] | cp[i])) begin
                    rdy[i]  <= 1'b0;
                    lat[i]  <= int'($urandom_range(3, 1));
                    pend[i] <= ce[i];
                    if (i == 0) begin
                        ev0.push_back(cp[i] ? EV_P : (cs[i] ? EV_S : int'(td[i])));
                        if (cs[i] && first_st < 0) first_st <= cyc;
                    end else ev1.push_back(cp[i] ? EV_P : (cs[i] ? EV_S : int'(td[i])));
                end
            end
        end
        if ((done0 && busy0) || (done1 && busy1)) viol <= viol + 1;
        if (done0) dcnt0 <= dcnt0 + 1;
        if (done1) dcnt1 <= dcnt1 + 1;
        if (reset && start0 && !busy0) begin
            ev0.delete(); dcnt0 <= 0; byte_no <= 0; st_cyc <= cyc; first_st <= -1;
        end
        if (reset && start1 && !busy1) begin ev1.delete(); dcnt1 <= 0; end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load0(input logic [0:7][15:0] r, input logic [31:0] nm);
        for (int i = 0; i < D0; i++) rom0[i] = r[i];
        for (int i = 0; i < 32; i++) nack_tab[i] = nm[i];
        for (int i = 32; i < 1024; i++) nack_tab[i] = 1'b0;
    endtask

    task automatic pulse_start0(input bit with_abort);
        @(negedge clk); start0 = 1'b1; abort0 = with_abort;
        @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
    endtask

    task automatic wait_done0(input string nm);
        int n = 0;
        while (dcnt0 == 0 && n < BUDGET) begin @(negedge clk); n++; end
        chk({nm, " done seen"}, int'(dcnt0 != 0), 1);
        if (dcnt0 == 0) begin
            reset = 1'b0; repeat (2) @(negedge clk); reset = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    // Transaction-level expectation: every WRITE entry is START, bytes, STOP per attempt;
    // an attempt ends at the first NACKed byte; MR retries then error.
    int exp_err, exp_idx;
    task automatic build_expect();
        int bn, by[3];
        bit ok;
        bn = 0; exp_ev.delete(); exp_err = 0; exp_idx = 0;
        for (int e = 0; e < D0; e++) begin
            exp_idx = e;
            if (rom0[e] == 16'hFFFF) return;
            if (rom0[e][15:8] == 8'hFF) continue;
            by[0] = 32'h42; by[1] = int'(rom0[e][15:8]); by[2] = int'(rom0[e][7:0]);
            ok = 1'b0;
            for (int a = 0; a <= MR && !ok; a++) begin
                ok = 1'b1;
                exp_ev.push_back(EV_S);
                for (int b = 0; b < 3; b++) begin
                    exp_ev.push_back(by[b]);
                    if (nack_tab[bn]) begin bn++; ok = 1'b0; break; end
                    bn++;
                end
                exp_ev.push_back(EV_P);
            end
            if (!ok) begin exp_err = 1; return; end
        end
    endtask

    task automatic cmp_model0(input string nm);
        int bad = -1;
        build_expect();
        chk({nm, " ev count"}, ev0.size(), exp_ev.size());
        for (int i = 0; i < ev0.size() && i < exp_ev.size(); i++)
            if (bad < 0 && ev0[i] != exp_ev[i]) bad = i;
        chk({nm, " first ev diff idx"}, bad, -1);
        chk({nm, " error"}, int'(err0), exp_err);
        chk({nm, " cur_index"}, int'(idx0), exp_idx);
        chk({nm, " done pulses"}, dcnt0, 1);
    endtask

    function automatic int count_ev(input int kind);
        int n = 0;
        foreach (ev0[i]) if ((kind < 0 && ev0[i] < 256) || ev0[i] == kind) n++;
        return n;
    endfunction

    typedef struct {
        logic [0:7][15:0] rom;
        logic [31:0]      nmask;
        int               e_st, e_en, e_err, e_idx;
    } vec_t;
    vec_t vt[6];

    initial begin
        int r, p, bad;
        int exp1[$];
        vt[0] = '{rom: {16'h1280, 16'h1101, {6{16'hFFFF}}}, nmask: 32'h0,   e_st: 2, e_en: 6,  e_err: 0, e_idx: 2};
        vt[1] = '{rom: {16'h1280, {7{16'hFFFF}}},           nmask: 32'h24,  e_st: 3, e_en: 9,  e_err: 0, e_idx: 1};
        vt[2] = '{rom: {16'h1280, {7{16'hFFFF}}},           nmask: 32'h924, e_st: 4, e_en: 12, e_err: 1, e_idx: 0};
        vt[3] = '{rom: {16'hFF00, 16'h5566, {6{16'hFFFF}}}, nmask: 32'h0,   e_st: 1, e_en: 3,  e_err: 0, e_idx: 2};
        vt[4] = '{rom: {8{16'hFF00}},                       nmask: 32'h0,   e_st: 0, e_en: 0,  e_err: 0, e_idx: 7};
        vt[5] = '{rom: {16'hFFFE, {7{16'hFFFF}}},           nmask: 32'h0,   e_st: 0, e_en: 0,  e_err: 0, e_idx: 1};
        for (int i = 0; i < D1; i++) rom1[i] = 24'hFFFFFF;
        rom1[0] = 24'h300A56;
        load0({8{16'hFFFF}}, 32'h0);

        repeat (3) @(negedge clk);
        chk("reset dut0", int'({busy0, done0, err0, ist0, ien0, istp0, idx0, raddr0, txd0}), 0);
        chk("reset dut1", int'({busy1, done1, err1, ist1, ien1, istp1, idx1, raddr1, txd1}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vt[v]) begin
            load0(vt[v].rom, vt[v].nmask);
            pulse_start0(1'b0);
            if (v == 0) chk("busy after start", int'(busy0), 1);
            wait_done0($sformatf("vec%0d", v));
            chk($sformatf("vec%0d starts", v), count_ev(EV_S), vt[v].e_st);
            chk($sformatf("vec%0d stops", v), count_ev(EV_P), vt[v].e_st);
            chk($sformatf("vec%0d bytes", v), count_ev(-1), vt[v].e_en);
            chk($sformatf("vec%0d error", v), int'(err0), vt[v].e_err);
            chk($sformatf("vec%0d cur_index", v), int'(idx0), vt[v].e_idx);
            cmp_model0($sformatf("vec%0d", v));
        end

        // start-to-first-START latency, without and with an in-table delay
        load0({16'h1280, {7{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0); wait_done0("lat0");
        chk("latency write", first_st - st_cyc, 4);
        load0({16'hFF00, 16'h1234, {6{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0); wait_done0("lat0d");
        chk("latency zero delay", first_st - st_cyc, 8);
        load0({16'hFF05, 16'h1234, {6{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0); wait_done0("lat5d");
        chk("latency 5-unit delay", first_st - st_cyc, 58);

        // abort mid-byte, plus a start while busy that must be ignored
        load0({16'h1280, 16'h1101, {6{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0);
        r = 0;
        while (ev0.size() < 3 && r < BUDGET) begin @(negedge clk); r++; end
        abort0 = 1'b1; @(negedge clk); abort0 = 1'b0;
        start0 = 1'b1; @(negedge clk); start0 = 1'b0;
        wait_done0("abort");
        exp1 = '{EV_S, 32'h42, 32'h12, EV_P};
        bad = (ev0.size() == 4) ? -1 : 99;
        foreach (exp1[i]) if (bad < 0 && ev0[i] != exp1[i]) bad = i;
        chk("abort ev seq", bad, -1);
        chk("abort error", int'(err0), 1);
        chk("abort cur_index", int'(idx0), 0);
        chk("abort done pulses", dcnt0, 1);

        // start+abort together while idle: start wins and clears error
        pulse_start0(1'b1);
        chk("error cleared on start", int'(err0), 0);
        wait_done0("start+abort");
        cmp_model0("start+abort");

        // abort during a delay entry
        load0({16'hFF05, 16'h1234, {6{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0);
        repeat (10) @(negedge clk);
        abort0 = 1'b1; @(negedge clk); abort0 = 1'b0;
        wait_done0("abort delay");
        chk("abort delay error", int'(err0), 1);
        chk("abort delay no cmds", ev0.size(), 0);

        // reset mid-transaction
        load0({16'h1280, 16'h1101, {6{16'hFFFF}}}, 32'h0);
        pulse_start0(1'b0);
        r = 0;
        while (ev0.size() < 2 && r < BUDGET) begin @(negedge clk); r++; end
        reset = 1'b0; @(negedge clk);
        chk("mid reset outputs", int'({busy0, done0, err0, ist0, ien0, istp0, idx0, txd0}), 0);
        @(negedge clk); reset = 1'b1; repeat (2) @(negedge clk);

        // 2-byte register address instance
        @(negedge clk); start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        r = 0;
        while (dcnt1 == 0 && r < BUDGET) begin @(negedge clk); r++; end
        chk("dut1 done seen", int'(dcnt1 != 0), 1);
        repeat (4) @(negedge clk);
        exp1 = '{EV_S, 32'h42, 32'h30, 32'h0A, 32'h56, EV_P};
        bad = (ev1.size() == 6) ? -1 : 99;
        foreach (exp1[i]) if (bad < 0 && ev1[i] != exp1[i]) bad = i;
        chk("dut1 ev seq", bad, -1);
        chk("dut1 error", int'(err1), 0);
        chk("dut1 cur_index", int'(idx1), 1);

        // randomized tables and NACK patterns
        for (int it = 0; it < 30; it++) begin
            p = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 15 : 60);
            for (int e = 0; e < D0; e++) begin
                r = int'($urandom_range(99, 0));
                if (r < 72)      rom0[e] = {8'($urandom_range(254, 0)), 8'($urandom)};
                else if (r < 92) rom0[e] = {8'hFF, 8'($urandom_range(3, 0))};
                else             rom0[e] = 16'hFFFF;
            end
            for (int k = 0; k < 1024; k++) nack_tab[k] = (int'($urandom_range(99, 0)) < p);
            pulse_start0(1'b0);
            wait_done0($sformatf("rand%0d", it));
            cmp_model0($sformatf("rand%0d", it));
        end

        chk("protocol violations", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
